// File: rtl/cp0_timer.sv
// Minimal MIPS-style CP0: status/cause/EPC/BadVAddr exception bookkeeping
// plus a prescaled Count/Compare timer that raises a sticky interrupt.
module cp0_timer #(
   parameter int          NUM_HWINT  = 5,
   parameter int          COUNT_DIV  = 1,
   parameter logic [31:0] PRID_VALUE = 32'h0000_4330
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           rd_addr,
   input  logic [4:0]           wr_addr,
   input  logic [31:0]          wr_data,
   input  logic                 wr_en,
   input  logic                 eret,
   input  logic [4:0]           exc_code,
   input  logic [31:0]          exc_pc,
   input  logic                 exc_bd,
   input  logic [31:0]          exc_badvaddr,
   input  logic [NUM_HWINT-1:0] hw_int,
   output logic [31:0]          rd_data,
   output logic [31:0]          epc,
   output logic                 exc_req,
   output logic                 timer_irq
);

   localparam int         NI     = NUM_HWINT + 1;
   localparam logic [7:0] DIV_M1 = 8'(COUNT_DIV - 1);

   logic [NI-1:0] r_im;
   logic [NI-1:0] r_ip;
   logic          r_exl;
   logic          r_ie;
   logic          r_bd;
   logic [4:0]    r_exccode;
   logic [31:0]   r_epc;
   logic [31:0]   r_badva;
   logic [31:0]   r_count;
   logic [31:0]   r_compare;
   logic [7:0]    r_pre;
   logic          r_tirq;

   logic [NI-1:0] w_irq_vec;
   logic          w_int_req;
   logic          w_exc;
   logic          w_tick;
   logic          w_wr;
   logic [5:0]    w_im6;
   logic [5:0]    w_ip6;
   logic [31:0]   w_sr;
   logic [31:0]   w_cause;

   assign w_irq_vec = {r_tirq, hw_int};
   assign w_int_req = (|(w_irq_vec & r_im)) & r_ie & ~r_exl;
   // Gated by reset so a stray exc_code cannot request while held in reset.
   assign w_exc     = reset & (w_int_req | (~r_exl & (exc_code != 5'd0)));
   assign w_tick    = (r_pre == DIV_M1);
   // A write only lands when neither an exception nor eret claims the cycle.
   assign w_wr      = wr_en & ~w_exc & ~eret;

   assign w_im6   = 6'(r_im);
   assign w_ip6   = 6'(r_ip);
   assign w_sr    = {16'h0, w_im6, 8'h0, r_exl, r_ie};
   assign w_cause = {r_bd, 15'h0, w_ip6, 3'h0, r_exccode, 2'h0};

   assign exc_req   = w_exc;
   assign epc       = r_epc;
   assign timer_irq = r_tirq;

   always_comb begin
      rd_data = 32'h0;
      case (rd_addr)
         5'd8:    rd_data = r_badva;
         5'd9:    rd_data = r_count;
         5'd11:   rd_data = r_compare;
         5'd12:   rd_data = w_sr;
         5'd13:   rd_data = w_cause;
         5'd14:   rd_data = r_epc;
         5'd15:   rd_data = PRID_VALUE;
         default: rd_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_im      <= '0;
         r_ip      <= '0;
         r_exl     <= 1'b0;
         r_ie      <= 1'b0;
         r_bd      <= 1'b0;
         r_exccode <= 5'd0;
         r_epc     <= 32'h0;
         r_badva   <= 32'h0;
      end else begin
         r_ip <= w_irq_vec;
         if (w_exc) begin
            r_exl     <= 1'b1;
            r_bd      <= exc_bd;
            r_exccode <= w_int_req ? 5'd0 : exc_code;
            r_epc     <= exc_bd ? exc_pc - 32'd4 : exc_pc;
            if (!w_int_req && (exc_code == 5'd4 || exc_code == 5'd5))
               r_badva <= exc_badvaddr;
         end else if (eret) begin
            r_exl <= 1'b0;
         end else if (wr_en) begin
            if (wr_addr == 5'd12) begin
               r_im  <= wr_data[10 +: NI];
               r_exl <= wr_data[1];
               r_ie  <= wr_data[0];
            end else if (wr_addr == 5'd14) begin
               r_epc <= wr_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count   <= 32'h0;
         r_compare <= 32'h0;
         r_pre     <= 8'h0;
         r_tirq    <= 1'b0;
      end else begin
         if (w_wr && wr_addr == 5'd9) begin
            r_count <= wr_data;
            r_pre   <= 8'h0;
         end else if (w_tick) begin
            r_count <= r_count + 32'd1;
            r_pre   <= 8'h0;
         end else begin
            r_pre <= r_pre + 8'd1;
         end
         if (w_wr && wr_addr == 5'd11)
            r_compare <= wr_data;
         // Compare write clears and beats a same-edge match.
         if (w_wr && wr_addr == 5'd11)
            r_tirq <= 1'b0;
         else if (w_tick && (r_count + 32'd1 == r_compare))
            r_tirq <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cp0_timer.sv
// Randomized + directed bench for cp0_timer: a reference model predicts outputs
// each cycle into a queue; a monitor pops and compares against the DUT.
module tb_cp0_timer;

   localparam int NH  = 5;
   localparam int DIV = 4;
   localparam logic [31:0] PRID = 32'h0000_4330;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rd_addr, wr_addr, exc_code;
   logic [31:0] wr_data, exc_pc, exc_badvaddr;
   logic        wr_en, eret, exc_bd;
   logic [NH-1:0] hw_int;
   logic [31:0] rd_data, epc;
   logic        exc_req, timer_irq;

   always #5 clk = ~clk;

   cp0_timer #(.NUM_HWINT(NH), .COUNT_DIV(DIV), .PRID_VALUE(PRID)) dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_en(wr_en), .eret(eret), .exc_code(exc_code),
      .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr),
      .hw_int(hw_int), .rd_data(rd_data), .epc(epc), .exc_req(exc_req),
      .timer_irq(timer_irq));

   typedef struct {
      logic        rst_n;
      logic [4:0]  ra, wa, code;
      logic [31:0] wd, pc, bva;
      logic        we, er, bd;
      logic [NH-1:0] hw;
   } stim_t;

   typedef struct {
      logic [4:0]  ra;
      logic [31:0] rd, epc;
      logic        exc, tirq;
   } exp_t;

   stim_t s;
   exp_t  q[$];
   int    n_chk = 0, n_fail = 0;

   // Reference state: architectural fields, kept as plain numbers.
   logic [5:0]  m_im, m_ip;
   logic        m_exl, m_ie, m_bd, m_tirq;
   logic [4:0]  m_code;
   logic [31:0] m_epc, m_bva, m_count, m_cmp;
   int          m_pre;

   task automatic m_reset();
      m_im = 0; m_ip = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_tirq = 0;
      m_code = 0; m_epc = 0; m_bva = 0; m_count = 0; m_cmp = 0; m_pre = 0;
   endtask

   function automatic logic m_int_req();
      logic [5:0] v;
      v = {m_tirq, s.hw};
      return ((v & m_im) != 0) && m_ie && !m_exl;
   endfunction

   function automatic logic m_exc();
      return s.rst_n && (m_int_req() || (!m_exl && s.code != 0));
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         8:  return m_bva;
         9:  return m_count;
         11: return m_cmp;
         12: return {16'h0, m_im, 8'h0, m_exl, m_ie};
         13: return {m_bd, 15'h0, m_ip, 3'h0, m_code, 2'h0};
         14: return m_epc;
         15: return PRID;
         default: return 32'h0;
      endcase
   endfunction

   // One rising edge of the architectural rules.
   task automatic m_step();
      logic intr, exc, wr, tick, hit;
      intr = m_int_req();
      exc  = m_exc();
      wr   = s.we && !exc && !s.er;
      tick = (m_pre == DIV - 1);
      hit  = tick && (m_count + 32'd1 == m_cmp);
      m_ip = {m_tirq, s.hw};
      if (exc) begin
         m_exl  = 1;
         m_bd   = s.bd;
         m_code = intr ? 5'd0 : s.code;
         m_epc  = s.bd ? s.pc - 4 : s.pc;
         if (!intr && (s.code == 4 || s.code == 5)) m_bva = s.bva;
      end else if (s.er) begin
         m_exl = 0;
      end
      if (wr && s.wa == 12) begin
         m_im = s.wd[15:10]; m_exl = s.wd[1]; m_ie = s.wd[0];
      end
      if (wr && s.wa == 14) m_epc = s.wd;
      if (wr && s.wa == 9) begin
         m_count = s.wd; m_pre = 0;
      end else begin
         m_pre = tick ? 0 : m_pre + 1;
         if (tick) m_count = m_count + 1;
      end
      if (wr && s.wa == 11) begin
         m_cmp = s.wd; m_tirq = 0;
      end else if (hit) begin
         m_tirq = 1;
      end
   endtask

   task automatic run_cyc();
      exp_t e;
      @(negedge clk);
      reset = s.rst_n; rd_addr = s.ra; wr_addr = s.wa; wr_data = s.wd;
      wr_en = s.we; eret = s.er; exc_code = s.code; exc_pc = s.pc;
      exc_bd = s.bd; exc_badvaddr = s.bva; hw_int = s.hw;
      if (!s.rst_n) m_reset();
      #1;
      e.ra = s.ra; e.rd = m_read(s.ra); e.epc = m_epc;
      e.exc = m_exc(); e.tirq = m_tirq;
      q.push_back(e);
      if (s.rst_n) m_step();
   endtask

   task automatic idle(input logic [4:0] ra);
      s.ra = ra; s.we = 0; s.er = 0; s.code = 0; s.bd = 0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [4:0] ra);
      idle(ra); s.we = 1; s.wa = a; s.wd = d;
      run_cyc();
      s.we = 0;
   endtask

   task automatic wait_n(input int n, input logic [4:0] ra);
      idle(ra);
      repeat (n) run_cyc();
   endtask

   always begin
      exp_t e;
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
         e = q.pop_front();
         n_chk += 4;
         if (rd_data !== e.rd) begin
            n_fail++;
            $display("FAIL rd_data[%0d] got=%h exp=%h", e.ra, rd_data, e.rd);
         end
         if (epc !== e.epc) begin
            n_fail++;
            $display("FAIL epc got=%h exp=%h", epc, e.epc);
         end
         if (exc_req !== e.exc) begin
            n_fail++;
            $display("FAIL exc_req got=%b exp=%b", exc_req, e.exc);
         end
         if (timer_irq !== e.tirq) begin
            n_fail++;
            $display("FAIL timer_irq got=%b exp=%b", timer_irq, e.tirq);
         end
      end
   end

   initial begin
      s = '{rst_n: 1'b0, ra: 5'd15, wa: 5'd0, code: 5'd0, wd: 32'h0,
            pc: 32'h0, bva: 32'h0, we: 1'b0, er: 1'b0, bd: 1'b0, hw: '0};
      m_reset();
      // Reset state, with noise on exc_code that must not raise exc_req.
      for (int a = 8; a <= 16; a++) begin
         s.ra = 5'(a); s.code = 5'(a); run_cyc();
      end
      s.code = 0; s.rst_n = 1;

      // Timer interrupt taken as an interrupt (ExcCode 0).
      wr(12, 32'h0000_8001, 12);
      wr(11, 32'd5, 11);
      wr(9, 32'd0, 9);
      wait_n(5 * DIV + 2, 9);
      s.pc = 32'h0000_2000; wait_n(2, 13);
      s.er = 1; run_cyc(); s.er = 0;

      // Delay-slot exception, then same stimulus again blocked by EXL.
      wr(12, 32'h0000_0000, 12);
      wr(11, 32'h0000_1000, 11);
      s.ra = 14; s.code = 12; s.bd = 1; s.pc = 32'h3010;
      run_cyc(); run_cyc();
      s.code = 0; s.bd = 0; s.ra = 13; run_cyc();
      s.er = 1; s.ra = 12; run_cyc(); s.er = 0;

      // Exception + eret + EPC write in the same cycle; BadVAddr capture.
      s.ra = 12; s.code = 4; s.bva = 32'h1233; s.pc = 32'h4000;
      s.er = 1; s.we = 1; s.wa = 14; s.wd = 32'hDEAD_BEEF;
      run_cyc();
      idle(8); run_cyc(); s.ra = 14; run_cyc(); s.ra = 12; run_cyc();
      s.er = 1; run_cyc(); s.er = 0;

      // Compare write in the cycle that would re-match.
      wr(11, 32'd100, 11);
      wr(9, 32'd98, 9);
      wait_n(2 * DIV + 2, 9);
      wr(9, 32'd98, 9);
      wait_n(2 * DIV - 1, 9);
      wr(11, 32'd100, 9);
      wait_n(3, 9);

      // Count wrap.
      wr(9, 32'hFFFF_FFFE, 9);
      wait_n(3 * DIV + 1, 9);

      // Masking and ignored Cause write.
      wr(12, 32'h0000_0001, 12);
      s.hw = 5'b00001; wait_n(2, 13);
      wr(12, 32'h0000_0401, 13);
      wait_n(1, 12);
      s.er = 1; run_cyc(); s.er = 0;
      wr(13, 32'hFFFF_FFFF, 13);
      s.hw = 0; s.er = 1; run_cyc(); s.er = 0;

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] amap[8];
         int r;
         amap = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
         s.ra = ($urandom_range(0, 7) == 0) ? 5'($urandom) : amap[$urandom_range(0, 7)];
         s.we = ($urandom_range(0, 2) == 0);
         s.wa = ($urandom_range(0, 5) == 0) ? 5'($urandom) : amap[$urandom_range(0, 6)];
         r = $urandom_range(0, 3);
         s.wd = $urandom;
         if (s.wa == 9 && r == 0) s.wd = m_cmp - 32'($urandom_range(0, 6));
         if (s.wa == 9 && r == 1) s.wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         if (s.wa == 11 && r == 0) s.wd = m_count + 32'($urandom_range(0, 3));
         if (s.wa == 12 && r != 0) s.wd[1] = 1'b0;
         s.er = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 11))
            0: s.code = 4;
            1: s.code = 5;
            2: s.code = 5'($urandom);
            default: s.code = 0;
         endcase
         s.pc = $urandom; s.bd = 1'($urandom); s.bva = $urandom;
         if ($urandom_range(0, 7) == 0) s.hw = NH'($urandom);
         run_cyc();
      end

      // Reset asserted mid-countdown, no clock edge between assert and check.
      wr(12, 32'h0000_8001, 12);
      wr(11, 32'd50, 11);
      wr(9, 32'd40, 9);
      wait_n(6, 9);
      s.rst_n = 0; s.code = 12;
      for (int a = 8; a <= 15; a++) begin
         s.ra = 5'(a); run_cyc();
      end
      s.rst_n = 1; s.code = 0;
      wait_n(DIV + 1, 9);

      repeat (2) @(negedge clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
